bus_mgr_resp: RTL and testbench
===============================

Name: bus_mgr_resp

Overview:
- Responder (MGR end) of the as/rw/ds/da strobe bus; answers cycles issued by the bus reader (RD end).
- Holds a 2^AW x DW register array that owning logic fills through a local write port.
- Returns read data after a programmable wait-state count using a four-phase ds/da handshake.
- Counts serviced reads and protocol errors for debug.

Parameters:
- AW, 8, bus address width; array depth is 2^AW.
- DW, 8, bus data width.
- WAIT_CYCLES, 2, number of wait states between ds sampled high and da asserted; legal range 0..15.

Ports:
- clk  input  1  bus clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- as  input  1  address strobe from initiator; addr and rw valid while high.
- rw  input  1  1 = read cycle, 0 = write cycle.
- ds  input  1  data strobe from initiator.
- addr  input  AW  bus address.
- da  output  1  data acknowledge to initiator.
- data  output  DW  read data to initiator; valid while da is high.
- lcl_we  input  1  local array write enable.
- lcl_addr  input  AW  local write address.
- lcl_wdata  input  DW  local write data.
- rd_cnt  output  16  completed read cycles; wraps 0xFFFF->0.
- err_cnt  output  8  protocol errors plus rejected writes; saturates at 0xFF.

Behaviour:
- Reset (rst low, async): da=0, data=0, rd_cnt=0, err_cnt=0, FSM=IDLE. Array contents are not reset. Asserting reset mid-cycle drops da at once, with no glitch beyond the reset edge.
- FSM states: IDLE, ADDR, WAIT, ACK, DONE.
- IDLE: on as=1, latch addr and rw, then go to ADDR. ds alone is ignored.
- ADDR: on ds=1, load the wait counter with WAIT_CYCLES and go to WAIT. If as=0 first, return to IDLE with no count.
- WAIT:
  - Counter decrements each cycle.
  - At 0, go to ACK. If rw latched=1, data <= array[latched addr]. If rw=0, data <= 0.
  - da rises on the cycle ACK is entered.
  - With WAIT_CYCLES=0, da rises 1 clk after ds is sampled high.
  - Latency from ds sampled to da high is WAIT_CYCLES+1 clks.
- ACK:
  - da=1 and data are held stable until ds is sampled 0.
  - Then da <= 0 and data <= 0, and the FSM goes to DONE.
  - rd_cnt++ for reads. err_cnt++ for writes (write cycles are rejected on this bus).
- DONE: wait for as=0, then go to IDLE. This prevents one long as from being treated as two cycles.
- Protocol error: ds dropping or as dropping while in WAIT.
  - Abort to IDLE (DONE if as is still high); da stays 0.
  - err_cnt++; rd_cnt unchanged.
- as dropping in ACK while ds is still high is tolerated: the cycle completes on ds low.
- Local write:
  - array[lcl_addr] <= lcl_wdata on any cycle, independent of the FSM.
  - A read samples the array on WAIT->ACK. A local write to the same address on that same edge is not seen; the old value is returned.
  - A local write to the same address during ACK does not change data already driven.
- Counter overlap: a rejected write and a protocol error cannot occur in the same cycle, so err_cnt increments by at most 1 per clk.

Test Plan:
- Reset: rst=0 mid-ACK -> da=0, data=0, rd_cnt=0, err_cnt=0 asynchronously; next cycle after rst=1 is handled from IDLE.
- Basic read, WAIT_CYCLES=2: lcl write 0x5A to 0x10; read addr 0x10 -> da high exactly 3 clks after ds sampled, data=0x5A held until ds low; rd_cnt=1.
- Back-to-back reads of 0x00..0xFF, each preloaded with addr^0xA5, WAIT_CYCLES=0 -> each returns addr^0xA5 with da 1 clk after ds; rd_cnt=256.
- Write cycle rw=0 at 0x20 -> da asserted, data=0x00, array[0x20] unchanged, err_cnt=1, rd_cnt unchanged.
- Abort: ds dropped during WAIT (WAIT_CYCLES=4) -> da never rises, err_cnt +1, next normal read succeeds.
- Collision: lcl write 0x77 to 0x30 (old 0x11) on the WAIT->ACK edge -> data=0x11. A second read -> 0x77. err_cnt driven past 255 errors stays 0xFF.

Source files
------------

// File: rtl/bus_mgr_resp.sv
// MGR-end responder for the as/rw/ds/da strobe bus.
// Serves reads from a locally written array after a fixed wait count.
module bus_mgr_resp #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          as,
  input  logic          rw,
  input  logic          ds,
  input  logic [AW-1:0] addr,
  output logic          da,
  output logic [DW-1:0] data,
  input  logic          lcl_we,
  input  logic [AW-1:0] lcl_addr,
  input  logic [DW-1:0] lcl_wdata,
  output logic [15:0]   rd_cnt,
  output logic [7:0]    err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_ACK,
    S_DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] lat_addr;
  logic          lat_rw;
  logic [3:0]    cnt;

  logic [DW-1:0] mem [2**AW];

  // Array has no reset; contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (lcl_we)
      mem[lcl_addr] <= lcl_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      lat_addr <= '0;
      lat_rw   <= 1'b0;
      cnt      <= '0;
      da       <= 1'b0;
      data     <= '0;
      rd_cnt   <= '0;
      err_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (as) begin
            lat_addr <= addr;
            lat_rw   <= rw;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (!as) begin
            state <= S_IDLE;
          end else if (ds) begin
            cnt   <= 4'(WAIT_CYCLES);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!ds || !as) begin
            state <= as ? S_DONE : S_IDLE;
            if (err_cnt != 8'hff)
              err_cnt <= err_cnt + 8'd1;
          end else if (cnt == 4'd0) begin
            da    <= 1'b1;
            data  <= lat_rw ? mem[lat_addr] : '0;
            state <= S_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          // as may drop early here; only ds closes the cycle.
          if (!ds) begin
            da    <= 1'b0;
            data  <= '0;
            state <= S_DONE;
            if (lat_rw)
              rd_cnt <= rd_cnt + 16'd1;
            else if (err_cnt != 8'hff)
              err_cnt <= err_cnt + 8'd1;
          end
        end
        S_DONE: begin
          if (!as)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mgr_resp.sv
// Directed bench for bus_mgr_resp with WAIT_CYCLES=2.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_bus_mgr_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        as;
  logic        rw;
  logic        ds;
  logic [7:0]  addr;
  logic        da;
  logic [7:0]  data;
  logic        lcl_we;
  logic [7:0]  lcl_addr;
  logic [7:0]  lcl_wdata;
  logic [15:0] rd_cnt;
  logic [7:0]  err_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_mgr_resp #(
    .AW(8),
    .DW(8),
    .WAIT_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .as(as),
    .rw(rw),
    .ds(ds),
    .addr(addr),
    .da(da),
    .data(data),
    .lcl_we(lcl_we),
    .lcl_addr(lcl_addr),
    .lcl_wdata(lcl_wdata),
    .rd_cnt(rd_cnt),
    .err_cnt(err_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lcl_write(input logic [7:0] a,
                           input logic [7:0] d);
    lcl_we    = 1'b1;
    lcl_addr  = a;
    lcl_wdata = d;
    tick();
    lcl_we    = 1'b0;
  endtask

  // Runs a cycle up to da high; lat counts edges after ds sampled.
  // With coll set, a local write of 0x77 lands on the ACK edge.
  task automatic begin_cycle(input logic [7:0] a,
                             input logic r,
                             input bit coll,
                             output logic [7:0] d,
                             output int lat);
    as   = 1'b1;
    rw   = r;
    addr = a;
    tick();
    ds = 1'b1;
    tick();
    lat = 0;
    d   = 8'h00;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (da === 1'b1) break;
      if (coll && lat == 2) begin
        lcl_we    = 1'b1;
        lcl_addr  = a;
        lcl_wdata = 8'h77;
      end
    end
    lcl_we = 1'b0;
    if (da !== 1'b1) chk("da_timeout", 32'(da), 32'd1);
    d = data;
  endtask

  task automatic end_cycle();
    ds = 1'b0;
    tick();
    chk("da_drop", 32'(da), 32'd0);
    chk("data_drop", 32'(data), 32'd0);
    as = 1'b0;
    tick();
  endtask

  logic [7:0] d;
  int         lat;
  int         bad_lat;

  initial begin
    rst       = 1'b0;
    as        = 1'b0;
    rw        = 1'b0;
    ds        = 1'b0;
    addr      = 8'h00;
    lcl_we    = 1'b0;
    lcl_addr  = 8'h00;
    lcl_wdata = 8'h00;
    tick();
    tick();
    chk("rst_da", 32'(da), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // basic read, three clocks from ds to da
    lcl_write(8'h10, 8'h5A);
    begin_cycle(8'h10, 1'b1, 1'b0, d, lat);
    chk("basic_lat", 32'(lat), 32'd3);
    chk("basic_data", 32'(d), 32'h5A);
    tick();
    chk("hold_da", 32'(da), 32'd1);
    tick();
    chk("hold_data", 32'(data), 32'h5A);
    end_cycle();
    chk("basic_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("basic_err_cnt", 32'(err_cnt), 32'd0);

    // async reset while in ACK
    begin_cycle(8'h10, 1'b1, 1'b0, d, lat);
    chk("pre_rst_da", 32'(da), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_da", 32'(da), 32'd0);
    chk("arst_data", 32'(data), 32'd0);
    chk("arst_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    as = 1'b0;
    ds = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    begin_cycle(8'h10, 1'b1, 1'b0, d, lat);
    chk("post_rst_data", 32'(d), 32'h5A);
    end_cycle();
    chk("post_rst_rd_cnt", 32'(rd_cnt), 32'd1);

    // write cycle is acked with zero data and counted as error
    lcl_write(8'h20, 8'h33);
    begin_cycle(8'h20, 1'b0, 1'b0, d, lat);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_data", 32'(d), 32'h00);
    end_cycle();
    chk("wr_err_cnt", 32'(err_cnt), 32'd1);
    chk("wr_rd_cnt", 32'(rd_cnt), 32'd1);
    begin_cycle(8'h20, 1'b1, 1'b0, d, lat);
    chk("wr_array_kept", 32'(d), 32'h33);
    end_cycle();
    chk("wr_rd_cnt2", 32'(rd_cnt), 32'd2);

    // ds dropped during WAIT, as still high
    as   = 1'b1;
    rw   = 1'b1;
    addr = 8'h10;
    tick();
    ds = 1'b1;
    tick();
    tick();
    ds = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_da", 32'(da), 32'd0);
    end
    chk("abort_err_cnt", 32'(err_cnt), 32'd2);
    chk("abort_rd_cnt", 32'(rd_cnt), 32'd2);
    as = 1'b0;
    tick();
    begin_cycle(8'h10, 1'b1, 1'b0, d, lat);
    chk("abort_next_lat", 32'(lat), 32'd3);
    chk("abort_next_data", 32'(d), 32'h5A);
    end_cycle();
    chk("abort_next_rd_cnt", 32'(rd_cnt), 32'd3);

    // local write on the WAIT->ACK edge returns the old value
    lcl_write(8'h30, 8'h11);
    begin_cycle(8'h30, 1'b1, 1'b1, d, lat);
    chk("coll_old", 32'(d), 32'h11);
    lcl_write(8'h30, 8'h55);
    chk("ack_data_stable", 32'(data), 32'h11);
    lcl_write(8'h30, 8'h77);
    end_cycle();
    begin_cycle(8'h30, 1'b1, 1'b0, d, lat);
    chk("coll_new", 32'(d), 32'h77);
    end_cycle();
    chk("coll_rd_cnt", 32'(rd_cnt), 32'd5);

    // full sweep, each location holds addr^0xA5
    for (int a = 0; a < 256; a++)
      lcl_write(8'(a), 8'(a) ^ 8'hA5);
    bad_lat = 0;
    for (int a = 0; a < 256; a++) begin
      begin_cycle(8'(a), 1'b1, 1'b0, d, lat);
      chk($sformatf("sweep_%0h", a), 32'(d),
          32'(8'(a) ^ 8'hA5));
      if (lat != 3) bad_lat++;
      end_cycle();
    end
    chk("sweep_lat_errs", 32'(bad_lat), 32'd0);
    chk("sweep_rd_cnt", 32'(rd_cnt), 32'd261);

    // drive err_cnt well past 255
    for (int i = 0; i < 260; i++) begin
      begin_cycle(8'h20, 1'b0, 1'b0, d, lat);
      end_cycle();
      if (i == 252)
        chk("err_at_255", 32'(err_cnt), 32'hFF);
    end
    chk("err_sat", 32'(err_cnt), 32'hFF);
    chk("err_sat_rd_cnt", 32'(rd_cnt), 32'd261);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
